// File: rtl/hyperbus_phy_dispatch.sv
// Order FIFO: remembers which PHY each split-mode transfer was routed to.
// Latency: head visible the cycle after push; pop retires the head at the next edge.
// Backpressure: exposes full/empty; push while full and pop while empty are ignored.
module hyperbus_phy_dispatch_fifo #(
  parameter int Width    = 1,
  parameter int LogDepth = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int Depth = 2**LogDepth;

  logic [Width-1:0]    mem [Depth];
  logic [LogDepth-1:0] wptr;
  logic [LogDepth-1:0] rptr;
  logic [LogDepth:0]   count;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == (LogDepth+1)'(Depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + LogDepth'(1);
      if (do_pop)  rptr <= rptr + LogDepth'(1);
      count <= count + (LogDepth+1)'(do_push) - (LogDepth+1)'(do_pop);
    end
  end

  // entry storage; contents are only read while count marks them live
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// Dispatcher between the AXI front-end and NumPhys PHYs: ganged broadcast or split per-address routing.
// Latency: zero-cycle combinational issue and return paths; mode changes take effect only when idle.
// Backpressure: upstream ready follows PHY readies, order FIFO space and the outstanding limit.
module hyperbus_phy_dispatch #(
  parameter int NumPhys       = 2,
  parameter int NumChips      = 2,
  parameter int AddrWidth     = 32,
  parameter int BurstWidth    = 16,
  parameter int PhyDataWidth  = 16,
  parameter int SelLsb        = 2,
  parameter int OrderLogDepth = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cfg_split_i,
  input  logic [AddrWidth-1:0]            trans_addr_i,
  input  logic                            trans_write_i,
  input  logic [BurstWidth-1:0]           trans_burst_i,
  input  logic [NumChips-1:0]             trans_cs_i,
  input  logic                            trans_valid_i,
  output logic                            trans_ready_o,
  output logic [NumPhys*AddrWidth-1:0]    phy_trans_addr_o,
  output logic [NumPhys-1:0]              phy_trans_write_o,
  output logic [NumPhys*BurstWidth-1:0]   phy_trans_burst_o,
  output logic [NumPhys*NumChips-1:0]     phy_trans_cs_o,
  output logic [NumPhys-1:0]              phy_trans_valid_o,
  input  logic [NumPhys-1:0]              phy_trans_ready_i,
  input  logic [NumPhys*PhyDataWidth-1:0] phy_rx_data_i,
  input  logic [NumPhys-1:0]              phy_rx_last_i,
  input  logic [NumPhys-1:0]              phy_rx_error_i,
  input  logic [NumPhys-1:0]              phy_rx_valid_i,
  output logic [NumPhys-1:0]              phy_rx_ready_o,
  output logic [NumPhys*PhyDataWidth-1:0] rx_data_o,
  output logic                            rx_last_o,
  output logic                            rx_error_o,
  output logic                            rx_valid_o,
  input  logic                            rx_ready_i,
  input  logic [NumPhys-1:0]              phy_b_error_i,
  input  logic [NumPhys-1:0]              phy_b_valid_i,
  output logic [NumPhys-1:0]              phy_b_ready_o,
  output logic                            b_error_o,
  output logic                            b_valid_o,
  input  logic                            b_ready_i,
  output logic                            mode_split_o,
  output logic                            busy_o,
  output logic                            unexpected_o
);
  localparam int SelW = $clog2(NumPhys);
  localparam int CntW = OrderLogDepth + 2;
  localparam logic [CntW-1:0] CntMax = CntW'(2 * (2**OrderLogDepth));

  logic                mode_split;
  logic [CntW-1:0]     outstanding;
  logic [CntW-1:0]     cnt_up;
  logic [CntW-1:0]     cnt_dec;
  logic [CntW-1:0]     cnt_next;
  logic [NumPhys-1:0]  sent;
  logic                unexpected;
  logic                run;
  logic                sat;
  logic [SelW-1:0]     sel;
  logic                type_full;
  logic                trans_hs;
  logic                rx_done;
  logic                b_done;
  logic                rd_push, rd_pop, rd_full, rd_empty;
  logic                wr_push, wr_pop, wr_full, wr_empty;
  logic [SelW-1:0]     rd_head;
  logic [SelW-1:0]     wr_head;

  // while reset is asserted every handshake output is forced low so PHY valids are ignored
  assign run       = ~rst_i;
  assign sat       = (outstanding >= CntMax);
  assign sel       = trans_addr_i[SelLsb +: SelW];
  assign type_full = trans_write_i ? wr_full : rd_full;

  // every PHY sees the same transfer fields; only the valids differ
  assign phy_trans_addr_o  = {NumPhys{trans_addr_i}};
  assign phy_trans_write_o = {NumPhys{trans_write_i}};
  assign phy_trans_burst_o = {NumPhys{trans_burst_i}};
  assign phy_trans_cs_o    = {NumPhys{trans_cs_i}};

  // issue: ganged stream fork or split single-PHY routing; PHY valid is withheld when the
  // transfer cannot be accepted upstream, so no PHY ever receives a duplicate
  always_comb begin
    phy_trans_valid_o = '0;
    trans_ready_o     = 1'b0;
    if (run && !sat) begin
      if (mode_split) begin
        if (!type_full) begin
          phy_trans_valid_o[sel] = trans_valid_i;
          trans_ready_o          = phy_trans_ready_i[sel];
        end
      end else begin
        phy_trans_valid_o = {NumPhys{trans_valid_i}} & ~sent;
        trans_ready_o     = trans_valid_i & (&(sent | (phy_trans_valid_o & phy_trans_ready_i)));
      end
    end
  end

  assign trans_hs = trans_valid_i & trans_ready_o;
  assign rd_push  = mode_split & trans_hs & ~trans_write_i;
  assign wr_push  = mode_split & trans_hs & trans_write_i;

  // read return: join all PHYs when ganged, follow the read-order head when split
  always_comb begin
    rx_valid_o     = 1'b0;
    rx_data_o      = '0;
    rx_last_o      = 1'b0;
    rx_error_o     = 1'b0;
    phy_rx_ready_o = '0;
    if (run) begin
      if (mode_split) begin
        if (!rd_empty) begin
          rx_valid_o                   = phy_rx_valid_i[rd_head];
          rx_data_o[PhyDataWidth-1:0]  = phy_rx_data_i[rd_head*PhyDataWidth +: PhyDataWidth];
          rx_last_o                    = phy_rx_last_i[rd_head];
          rx_error_o                   = phy_rx_error_i[rd_head];
          phy_rx_ready_o[rd_head]      = rx_ready_i & phy_rx_valid_i[rd_head];
        end
      end else begin
        rx_valid_o     = &phy_rx_valid_i;
        rx_data_o      = phy_rx_data_i;
        rx_last_o      = phy_rx_last_i[0];
        rx_error_o     = |phy_rx_error_i;
        phy_rx_ready_o = {NumPhys{rx_ready_i & rx_valid_o}};
      end
    end
  end

  // write response: same join / ordered-select scheme as the read path
  always_comb begin
    b_valid_o     = 1'b0;
    b_error_o     = 1'b0;
    phy_b_ready_o = '0;
    if (run) begin
      if (mode_split) begin
        if (!wr_empty) begin
          b_valid_o              = phy_b_valid_i[wr_head];
          b_error_o              = phy_b_error_i[wr_head];
          phy_b_ready_o[wr_head] = b_ready_i & phy_b_valid_i[wr_head];
        end
      end else begin
        b_valid_o     = &phy_b_valid_i;
        b_error_o     = |phy_b_error_i;
        phy_b_ready_o = {NumPhys{b_ready_i & b_valid_o}};
      end
    end
  end

  assign rx_done = rx_valid_o & rx_ready_i & rx_last_o;
  assign b_done  = b_valid_o & b_ready_i;
  assign rd_pop  = mode_split & rx_done;
  assign wr_pop  = mode_split & b_done;

  hyperbus_phy_dispatch_fifo #(.Width(SelW), .LogDepth(OrderLogDepth)) u_rd_order (
    .clk(clk_i), .rst(rst_i), .push(rd_push), .wdata(sel), .pop(rd_pop),
    .rdata(rd_head), .full(rd_full), .empty(rd_empty)
  );

  hyperbus_phy_dispatch_fifo #(.Width(SelW), .LogDepth(OrderLogDepth)) u_wr_order (
    .clk(clk_i), .rst(rst_i), .push(wr_push), .wdata(sel), .pop(wr_pop),
    .rdata(wr_head), .full(wr_full), .empty(wr_empty)
  );

  // next outstanding count; a read-last and a write response may retire together,
  // and a stray completion never wraps the counter below zero
  always_comb begin
    cnt_up   = outstanding + CntW'(trans_hs);
    cnt_dec  = CntW'(rx_done) + CntW'(b_done);
    cnt_next = (cnt_up >= cnt_dec) ? (cnt_up - cnt_dec) : '0;
  end

  // outstanding transfer counter
  always_ff @(posedge clk_i) begin
    if (rst_i) outstanding <= '0;
    else       outstanding <= cnt_next;
  end

  // ganged fork progress: remembers which PHYs already took the current transfer
  always_ff @(posedge clk_i) begin
    if (rst_i || mode_split || trans_hs) sent <= '0;
    else                                 sent <= sent | (phy_trans_valid_o & phy_trans_ready_i);
  end

  // mode switch only when fully idle so no transfer straddles two modes
  always_ff @(posedge clk_i) begin
    if (rst_i) mode_split <= 1'b0;
    else if (outstanding == '0 && sent == '0 && !trans_hs) mode_split <= cfg_split_i;
  end

  // sticky flag for a PHY response that has no matching order entry
  always_ff @(posedge clk_i) begin
    if (rst_i) unexpected <= 1'b0;
    else if (mode_split && ((rd_empty && |phy_rx_valid_i) || (wr_empty && |phy_b_valid_i)))
      unexpected <= 1'b1;
  end

  assign mode_split_o = mode_split;
  assign busy_o       = (outstanding != '0) | (|sent);
  assign unexpected_o = unexpected;
endmodule
